// File: rtl/ov_capture_pkg.sv
// ov_capture_pkg: shared FSM type, default geometry and counter widths for the OV7670 capture front end
package ov_capture_pkg;

   typedef enum logic [1:0] {SYNC, ACTIVE, END, ACTIVE_WAIT} ov_state_t;

   localparam int OV_LINE_PIXELS = 640;
   localparam int OV_FRAME_LINES = 480;
   localparam int OV_X_W         = 10;
   localparam int OV_Y_W         = 9;

endpackage

// File: rtl/ov_byte_pair.sv
// ov_byte_pair: pairs href-qualified bus bytes into 16-bit pixels, {first byte, second byte}
module ov_byte_pair (
   input  logic        ov_pclk,
   input  logic        rst,
   input  logic        en,
   input  logic [7:0]  p_data,
   output logic        phase,
   output logic [15:0] pixel_data,
   output logic        pixel_valid
);

   logic [7:0] hi;

   // phase 0 latches the high byte, phase 1 emits the pixel; a gap in en drops any dangling byte
   always_ff @(posedge ov_pclk or negedge rst)
      if (!rst) begin
         phase       <= 1'b0;
         hi          <= '0;
         pixel_data  <= '0;
         pixel_valid <= 1'b0;
      end else begin
         phase       <= en & ~phase;
         pixel_valid <= en & phase;
         if (en && !phase) hi <= p_data;
         if (en && phase) pixel_data <= {hi, p_data};
      end

endmodule

// File: rtl/ov_frame_capture.sv
// ov_frame_capture: OV7670 frame/line framing, pixel position tagging and geometry check (OV_CAPTURE_CHECK_EN enables frame_err)
module ov_frame_capture
   import ov_capture_pkg::*;
#(
   parameter int LINE_PIXELS = OV_LINE_PIXELS,
   parameter int FRAME_LINES = OV_FRAME_LINES
) (
   input  logic              ov_pclk,
   input  logic              rst,
   input  logic              vsync,
   input  logic              href,
   input  logic [7:0]        p_data,
   output logic [15:0]       pixel_data,
   output logic              pixel_valid,
   output logic [OV_X_W-1:0] pixel_x,
   output logic [OV_Y_W-1:0] pixel_y,
   output logic              line_done,
   output logic              frame_done,
   output logic              frame_err,
   output logic [7:0]        frame_count
);

   ov_state_t         state, state_nx;
   logic              vs_q, hr_q, vs_rise, vs_fall, hr_fall, en, phase, emit, frame_end;
   logic [OV_X_W-1:0] x;
   logic [OV_Y_W-1:0] y;

   assign vs_rise   = vsync & ~vs_q;
   assign vs_fall   = ~vsync & vs_q;
   assign hr_fall   = ~href & hr_q;
   assign en        = (state == ACTIVE) & href & ~vsync;
   assign emit      = en & phase;
   assign frame_end = (state == ACTIVE) & vs_rise;

   ov_byte_pair u_pair (
      .ov_pclk     (ov_pclk),
      .rst         (rst),
      .en          (en),
      .p_data      (p_data),
      .phase       (phase),
      .pixel_data  (pixel_data),
      .pixel_valid (pixel_valid)
   );

   // sync history for edge detection; cleared so a reset never fakes a vs_fall
   always_ff @(posedge ov_pclk or negedge rst)
      if (!rst) begin
         vs_q <= 1'b0;
         hr_q <= 1'b0;
      end else begin
         vs_q <= vsync;
         hr_q <= href;
      end

   // state register
   always_ff @(posedge ov_pclk or negedge rst)
      if (!rst) state <= SYNC;
      else state <= state_nx;

   // next state; END is the single frame_done cycle
   always_comb begin
      state_nx   = state;
      frame_done = (state == END);
      if (state == ACTIVE) state_nx = vs_rise ? END : ACTIVE;
      else if (state == END) state_nx = ACTIVE_WAIT;
      else if (vs_fall) state_nx = ACTIVE;
   end

   // column/row counters and the position tag latched with each emitted pixel
   always_ff @(posedge ov_pclk or negedge rst)
      if (!rst) begin
         x       <= '0;
         y       <= '0;
         pixel_x <= '0;
         pixel_y <= '0;
      end else begin
         if (hr_fall) x <= '0;
         else if (emit && x != '1) x <= x + 1'b1;
         if (vs_fall) y <= '0;
         else if (hr_fall && y != '1) y <= y + 1'b1;
         if (emit) begin
            pixel_x <= x;
            pixel_y <= y;
         end
      end

   // line strobe and frame counter; the count already includes the frame being reported
   always_ff @(posedge ov_pclk or negedge rst)
      if (!rst) begin
         line_done   <= 1'b0;
         frame_count <= '0;
      end else begin
         line_done <= (state == ACTIVE) & hr_fall;
         if (frame_end) frame_count <= frame_count + 1'b1;
      end

`ifdef OV_CAPTURE_CHECK_EN
   localparam logic [OV_X_W-1:0] LP = OV_X_W'(LINE_PIXELS);
   localparam logic [OV_Y_W:0]   FL = (OV_Y_W+1)'(FRAME_LINES);

   logic            err, line_err;
   logic [OV_Y_W:0] y_end;

   assign line_err = (state == ACTIVE) & ((hr_fall & (phase | (x != LP))) | (vs_rise & href));
   assign y_end    = {1'b0, y} + (OV_Y_W+1)'(hr_fall);

   // per-frame error accumulation, published at frame end and held until the next one
   always_ff @(posedge ov_pclk or negedge rst)
      if (!rst) begin
         err       <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (vs_fall) err <= 1'b0;
         else if (line_err) err <= 1'b1;
         if (frame_end) frame_err <= err | line_err | (y_end != FL);
      end
`else
   assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_ov_frame_capture.sv
// tb_ov_frame_capture: directed frame sequences with random data and gaps, checked against a byte-stream model
module tb_ov_frame_capture;

   localparam int LP = 8;
   localparam int FL = 4;
`ifdef OV_CAPTURE_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic        ov_pclk = 1'b0;
   logic        rst = 1'b0;
   logic        vsync = 1'b0;
   logic        href = 1'b0;
   logic [7:0]  p_data = '0;
   logic [15:0] pixel_data;
   logic        pixel_valid;
   logic [9:0]  pixel_x;
   logic [8:0]  pixel_y;
   logic        line_done, frame_done, frame_err;
   logic [7:0]  frame_count;

   int          nvec = 0;
   int          nerr = 0;
   logic        e_pv = 1'b0, e_ld = 1'b0, e_fd = 1'b0, e_fe = 1'b0;
   logic [15:0] e_pd = '0;
   logic [9:0]  e_px = '0;
   logic [8:0]  e_py = '0;
   logic [7:0]  e_fc = '0;
   bit          cap = 1'b0;
   bit          ferr = 1'b0;
   int          row = 0;
   logic [7:0]  hi = '0;

   ov_frame_capture #(.LINE_PIXELS(LP), .FRAME_LINES(FL)) dut (
      .ov_pclk     (ov_pclk),
      .rst         (rst),
      .vsync       (vsync),
      .href        (href),
      .p_data      (p_data),
      .pixel_data  (pixel_data),
      .pixel_valid (pixel_valid),
      .pixel_x     (pixel_x),
      .pixel_y     (pixel_y),
      .line_done   (line_done),
      .frame_done  (frame_done),
      .frame_err   (frame_err),
      .frame_count (frame_count)
   );

   always #5 ov_pclk = ~ov_pclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // check what the previous cycle's inputs should have produced, then drive new inputs
   task automatic tick(input logic vs, input logic hr, input logic [7:0] d);
      @(negedge ov_pclk);
      chk("pixel_valid", pixel_valid, e_pv);
      chk("line_done", line_done, e_ld);
      chk("frame_done", frame_done, e_fd);
      chk("frame_err", frame_err, e_fe);
      chk("frame_count", frame_count, e_fc);
      if (e_pv) begin
         chk("pixel_data", pixel_data, e_pd);
         chk("pixel_x", pixel_x, e_px);
         chk("pixel_y", pixel_y, e_py);
      end
      e_pv = 1'b0;
      e_ld = 1'b0;
      e_fd = 1'b0;
      vsync = vs;
      href = hr;
      p_data = d;
   endtask

   task automatic vs_up(input logic hr);
      tick(1'b1, hr, 8'($urandom));
      if (cap) begin
         if (hr || row != FL) ferr = 1'b1;
         e_fd = 1'b1;
         e_fe = CHK & ferr;
         e_fc = e_fc + 8'd1;
         cap = 1'b0;
      end
   endtask

   // vertical blanking with stray href pulses, then the vs_fall that opens a frame
   task automatic vs_down();
      repeat ($urandom_range(2, 4)) tick(1'b1, 1'b0, 8'($urandom));
      tick(1'b1, 1'b1, 8'($urandom));
      tick(1'b1, 1'b1, 8'($urandom));
      tick(1'b1, 1'b0, 8'($urandom));
      tick(1'b0, 1'b0, 8'h00);
      cap = 1'b1;
      row = 0;
      ferr = 1'b0;
      tick(1'b0, 1'b0, 8'h00);
   endtask

   task automatic line(input int nb, input bit abcd, input bit cut);
      logic [7:0] d;
      for (int b = 0; b < nb; b++) begin
         d = 8'($urandom);
         if (abcd && b == 0) d = 8'hAB;
         if (abcd && b == 1) d = 8'hCD;
         tick(1'b0, 1'b1, d);
         if (b % 2 == 0) hi = d;
         else if (cap) begin
            e_pv = 1'b1;
            e_pd = {hi, d};
            e_px = 10'(b / 2);
            e_py = 9'(row);
         end
      end
      if (cut) begin
         vs_up(1'b1);
         return;
      end
      tick(1'b0, 1'b0, 8'h00);
      if (cap) begin
         e_ld = 1'b1;
         if (nb % 2 != 0 || nb / 2 != LP) ferr = 1'b1;
         row++;
      end
      repeat ($urandom_range(1, 3)) tick(1'b0, 1'b0, 8'($urandom));
   endtask

   task automatic frame(input int nl, input int bad_row, input int abcd_row);
      for (int r = 0; r < nl; r++) line(r == bad_row ? 2 * LP - 1 : 2 * LP, r == abcd_row, 1'b0);
      vs_up(1'b0);
      vs_down();
   endtask

   task automatic do_reset();
      @(negedge ov_pclk);
      rst = 1'b0;
      #1;
      chk("rst_pixel_valid", pixel_valid, 1'b0);
      chk("rst_pixel_data", pixel_data, 16'h0000);
      chk("rst_pixel_x", pixel_x, 10'd0);
      chk("rst_pixel_y", pixel_y, 9'd0);
      chk("rst_line_done", line_done, 1'b0);
      chk("rst_frame_done", frame_done, 1'b0);
      chk("rst_frame_err", frame_err, 1'b0);
      chk("rst_frame_count", frame_count, 8'd0);
      e_pv = 1'b0;
      e_ld = 1'b0;
      e_fd = 1'b0;
      e_fe = 1'b0;
      e_fc = '0;
      cap = 1'b0;
      repeat (2) @(negedge ov_pclk);
      rst = 1'b1;
   endtask

   initial begin
      do_reset();
      line(2 * LP, 1'b0, 1'b0);
      line(2 * LP, 1'b0, 1'b0);
      vs_up(1'b0);
      vs_down();
      frame(FL, -1, 3);
      frame(FL, 1, -1);
      frame(FL, -1, -1);
      line(2 * LP, 1'b0, 1'b0);
      line(2 * LP, 1'b0, 1'b0);
      line(5, 1'b0, 1'b1);
      vs_down();
      frame(FL - 1, -1, -1);
      frame(FL, -1, -1);
      line(2 * LP, 1'b0, 1'b0);
      tick(1'b0, 1'b1, 8'($urandom));
      do_reset();
      tick(1'b0, 1'b1, 8'($urandom));
      tick(1'b0, 1'b0, 8'h00);
      line(2 * LP, 1'b0, 1'b0);
      line(2 * LP, 1'b0, 1'b0);
      vs_up(1'b0);
      vs_down();
      for (int f = 0; f < 256; f++) frame(FL, -1, -1);
      tick(1'b0, 1'b0, 8'h00);
      chk("frame_count_wrap", frame_count, 8'd0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
